// File: rtl/mmio_pkg.sv
// Shared definitions for the dmem MMIO bridge: register addresses,
// STATUS bit layout and the UART serializer state encoding.
package mmio_pkg;

    localparam logic [31:0] TXDATA_ADDR = 32'hFFFF_F000;
    localparam logic [31:0] STATUS_ADDR = 32'hFFFF_F004;

    localparam int STATUS_FULL    = 0;
    localparam int STATUS_EMPTY   = 1;
    localparam int STATUS_OVF     = 2;
    localparam int STATUS_CNT_LSB = 4;

    // Wide enough for the largest legal FIFO_DEPTH of 15.
    localparam int COUNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    function automatic logic [31:0] status_word(input logic             full,
                                                input logic             empty,
                                                input logic             overflow,
                                                input logic [COUNT_W-1:0] count);
        logic [31:0] word;
        word                              = '0;
        word[STATUS_FULL]                 = full;
        word[STATUS_EMPTY]                = empty;
        word[STATUS_OVF]                  = overflow;
        word[STATUS_CNT_LSB +: COUNT_W]   = count;
        return word;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding the UART serializer, with occupancy count
// and a sticky overflow flag for writes that arrive while full.
module uart_tx_fifo
    import mmio_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [7:0]         push_data,
    input  logic               pop,
    input  logic               ovf_clr,
    output logic [7:0]         head,
    output logic               full,
    output logic               empty,
    output logic               overflow,
    output logic [COUNT_W-1:0] count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(FIFO_DEPTH);

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == COUNT_MAX);
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // NOTE: storage is not reset; count/pointers alone define validity, so
    // the array can map onto plain RAM cells without a reset network.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + COUNT_W'(1);
                2'b01:   count <= count - COUNT_W'(1);
                default: count <= count;
            endcase
            // A drop and a clear on the same edge leave the flag set.
            if (push & full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dmem_mmio_uart.sv
// dmem-side bridge: decodes each access to data RAM, UART MMIO registers or
// nothing, and serializes queued TX bytes as 8N1 frames on tx.
module dmem_mmio_uart
    import mmio_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 12,
    parameter int FIFO_DEPTH     = 8,
    parameter int CLKS_PER_BIT   = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [31:0]               address_dmem,
    input  logic [31:0]               data,
    input  logic                      wren,
    input  logic                      hold,
    output logic [31:0]               q_dmem,
    output logic [RAM_ADDR_WIDTH-1:0] ram_address,
    output logic [31:0]               ram_data,
    output logic                      ram_wren,
    input  logic [31:0]               ram_q,
    output logic                      tx
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic               is_txdata;
    logic               is_status;
    logic               is_ram;
    logic               accept;
    logic               fifo_push;
    logic               fifo_pop;
    logic               ovf_clr;
    logic [7:0]         fifo_head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_ovf;
    logic [COUNT_W-1:0] fifo_count;

    tx_state_t          state, state_n;
    logic [BAUD_W-1:0]  baud_cnt, baud_n;
    logic [2:0]         bit_idx, bit_n;
    logic [7:0]         shift_reg, shift_n;
    logic               tx_n;
    logic               bit_end;

    assign is_txdata = (address_dmem == TXDATA_ADDR);
    assign is_status = (address_dmem == STATUS_ADDR);
    assign is_ram    = ~is_txdata & ~is_status
                     & ((address_dmem >> RAM_ADDR_WIDTH) == 32'd0);

    // Stalled stores repeat every cycle; only the final one touches MMIO state.
    assign accept    = wren & ~hold;
    assign fifo_push = accept & is_txdata;
    assign ovf_clr   = accept & is_status & data[STATUS_OVF];

    assign ram_address = address_dmem[RAM_ADDR_WIDTH-1:0];
    assign ram_data    = data;
    assign ram_wren    = wren & is_ram;

    always_comb begin
        q_dmem = '0;
        if (is_status) begin
            q_dmem = status_word(fifo_full, fifo_empty, fifo_ovf, fifo_count);
        end else if (is_ram) begin
            q_dmem = ram_q;
        end
    end

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (data[7:0]),
        .pop       (fifo_pop),
        .ovf_clr   (ovf_clr),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (fifo_ovf),
        .count     (fifo_count)
    );

    assign bit_end = (baud_cnt == BAUD_LAST);

    // NOTE: every value this block writes is given a default first, so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n  = state;
        baud_n   = baud_cnt;
        bit_n    = bit_idx;
        shift_n  = shift_reg;
        tx_n     = tx;
        fifo_pop = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_n  = fifo_head;
                    baud_n   = '0;
                    tx_n     = 1'b0;
                    state_n  = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    tx_n    = shift_reg[0];
                    state_n = ST_DATA;
                end else begin
                    baud_n = baud_cnt + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) begin
                        bit_n   = '0;
                        tx_n    = 1'b1;
                        state_n = ST_STOP;
                    end else begin
                        shift_n = {1'b0, shift_reg[7:1]};
                        bit_n   = bit_idx + 3'd1;
                        tx_n    = shift_reg[1];
                    end
                end else begin
                    baud_n = baud_cnt + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    baud_n = '0;
                    // Chain straight into the next start bit when more data waits.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_n  = fifo_head;
                        tx_n     = 1'b0;
                        state_n  = ST_START;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    baud_n = baud_cnt + BAUD_W'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_n;
            bit_idx   <= bit_n;
            shift_reg <= shift_n;
            tx        <= tx_n;
        end
    end

endmodule

// File: tb/tb_dmem_mmio_uart.sv
// Randomized scoreboard bench for dmem_mmio_uart: a queue-based reference
// model predicts load data and UART frames, monitors compare independently.
module tb_dmem_mmio_uart;

    localparam int AW     = 12;
    localparam int DEPTH  = 8;
    localparam int CPB    = 4;
    localparam int FRAME  = 10 * CPB;
    localparam logic [31:0] TXDATA = 32'hFFFF_F000;
    localparam logic [31:0] STATUS = 32'hFFFF_F004;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   address_dmem = '0;
    logic [31:0]   data = '0;
    logic          wren = 1'b0;
    logic          hold = 1'b0;
    logic [31:0]   q_dmem;
    logic [AW-1:0] ram_address;
    logic [31:0]   ram_data;
    logic          ram_wren;
    logic [31:0]   ram_q;
    logic          tx;

    dmem_mmio_uart #(
        .RAM_ADDR_WIDTH (AW),
        .FIFO_DEPTH     (DEPTH),
        .CLKS_PER_BIT   (CPB)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .hold         (hold),
        .q_dmem       (q_dmem),
        .ram_address  (ram_address),
        .ram_data     (ram_data),
        .ram_wren     (ram_wren),
        .ram_q        (ram_q),
        .tx           (tx)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    // Data RAM behind the bridge: asynchronous read, synchronous write.
    logic [31:0] env_mem [0:(1<<AW)-1];
    assign ram_q = env_mem[ram_address];
    initial begin
        for (int i = 0; i < (1 << AW); i++) env_mem[i] = '0;
        forever begin
            @(posedge clock);
            if (ram_wren) env_mem[ram_address] <= ram_data;
        end
    end

    typedef struct {
        logic [31:0]   q;
        logic          wren;
        logic [AW-1:0] addr;
    } rd_exp_t;

    typedef struct {
        logic [7:0] b;
        int         start;
    } tx_exp_t;

    rd_exp_t     rd_q[$];
    tx_exp_t     exp_tx[$];
    logic [7:0]  m_fifo[$];
    logic [31:0] ref_ram [0:(1<<AW)-1];
    bit          m_ovf = 0;
    int          m_rem = 0;

    int n_tests = 0;
    int n_fail  = 0;
    int frames_seen = 0;
    int last_start = 0;
    int prev_start = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_ram_addr(input logic [31:0] a);
        return (a != TXDATA) && (a != STATUS) && (a < (32'd1 << AW));
    endfunction

    // One edge of the reference model: a frame lasts FRAME cycles from its pop,
    // and the next byte is taken as soon as the line is free.
    task automatic model_step(input logic [31:0] a, input logic [31:0] d,
                              input logic w, input logic h);
        int      pre;
        bit      acc;
        tx_exp_t e;
        pre = m_fifo.size();
        acc = w && !h;
        if (m_rem <= 1) begin
            if (pre > 0) begin
                e.b     = m_fifo.pop_front();
                e.start = cyc + 1;
                exp_tx.push_back(e);
                m_rem = FRAME;
            end else begin
                m_rem = 0;
            end
        end else begin
            m_rem--;
        end
        if (acc && a == TXDATA) begin
            if (pre < DEPTH) m_fifo.push_back(d[7:0]);
            else m_ovf = 1;
        end else if (acc && a == STATUS && d[2]) begin
            m_ovf = 0;
        end
        if (w && is_ram_addr(a)) ref_ram[a[AW-1:0]] = d;
    endtask

    task automatic cycle(input logic [31:0] a, input logic [31:0] d,
                         input logic w, input logic h);
        rd_exp_t e;
        int      pre;
        @(posedge clock);
        #1;
        address_dmem = a;
        data         = d;
        wren         = w;
        hold         = h;
        pre          = m_fifo.size();
        e.addr       = a[AW-1:0];
        e.wren       = w && is_ram_addr(a);
        if (a == STATUS)
            e.q = (32'(pre) << 4) | (32'(m_ovf) << 2) | (32'(pre == 0) << 1) | 32'(pre == DEPTH);
        else if (is_ram_addr(a))
            e.q = ref_ram[a[AW-1:0]];
        else
            e.q = '0;
        rd_q.push_back(e);
        model_step(a, d, w, h);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        int budget;
        budget = 5000;
        while ((m_rem != 0 || m_fifo.size() != 0) && budget > 0) begin
            idle(1);
            budget--;
        end
        check("drain_done", 32'(m_rem == 0 && m_fifo.size() == 0), 32'd1);
        idle(2);
    endtask

    // Load-path monitor: one expected entry per driven cycle.
    initial begin
        rd_exp_t e;
        forever begin
            @(negedge clock);
            if (rd_q.size() > 0) begin
                e = rd_q.pop_front();
                check("q_dmem", q_dmem, e.q);
                check("ram_wren", 32'(ram_wren), 32'(e.wren));
                check("ram_address", 32'(ram_address), 32'(e.addr));
            end
        end
    end

    // Serial-line monitor: captures a whole frame from its first low sample.
    initial begin
        logic       samples [FRAME];
        logic [9:0] bits;
        int         start;
        bit         aborted;
        bit         shape_ok;
        tx_exp_t    e;
        forever begin
            @(negedge clock);
            if (reset && tx == 1'b0) begin
                start      = cyc;
                aborted    = 0;
                samples[0] = tx;
                for (int i = 1; i < FRAME; i++) begin
                    @(negedge clock);
                    if (!reset) begin
                        aborted = 1;
                        break;
                    end
                    samples[i] = tx;
                end
                if (!aborted) begin
                    shape_ok = 1;
                    for (int b = 0; b < 10; b++) begin
                        bits[b] = samples[b * CPB];
                        for (int j = 1; j < CPB; j++)
                            if (samples[b * CPB + j] !== bits[b]) shape_ok = 0;
                    end
                    frames_seen++;
                    prev_start = last_start;
                    last_start = start;
                    check("frame_bit_width", 32'(shape_ok), 32'd1);
                    check("stop_bit", 32'(bits[9]), 32'd1);
                    if (exp_tx.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got byte 0x%02h at cycle %0d, expected no frame",
                                 bits[8:1], start);
                    end else begin
                        e = exp_tx.pop_front();
                        check("frame_byte", 32'(bits[8:1]), 32'(e.b));
                        check("frame_start_cycle", 32'(start), 32'(e.start));
                    end
                end
            end
        end
    end

    initial begin
        int f0;
        int r;
        logic [31:0] a;
        logic [31:0] d;
        for (int i = 0; i < (1 << AW); i++) ref_ram[i] = '0;

        // Reset state, observed combinationally while reset is held.
        repeat (3) @(posedge clock);
        #1;
        address_dmem = STATUS;
        #1;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_status", q_dmem, 32'h0000_0002);
        @(posedge clock);
        #1;
        address_dmem = '0;
        reset = 1'b1;

        // RAM passthrough.
        cycle(32'd5, 32'h1234_5678, 1'b1, 1'b0);
        cycle(32'd5, 32'h0, 1'b0, 1'b0);
        #1;
        check("ram_load_5", q_dmem, 32'h1234_5678);
        check("ram_idle_tx", 32'(tx), 32'd1);

        // Single byte 0xA5.
        f0 = frames_seen;
        cycle(TXDATA, 32'h0000_00A5, 1'b1, 1'b0);
        drain();
        cycle(STATUS, 32'h0, 1'b0, 1'b0);
        #1;
        check("single_status", q_dmem, 32'h0000_0002);
        check("single_frames", 32'(frames_seen - f0), 32'd1);

        // Hold gating: three stalled cycles, one release.
        f0 = frames_seen;
        repeat (3) cycle(TXDATA, 32'h0000_003C, 1'b1, 1'b1);
        cycle(TXDATA, 32'h0000_003C, 1'b1, 1'b0);
        cycle(STATUS, 32'h0, 1'b0, 1'b0);
        #1;
        check("hold_count", 32'(q_dmem[7:4]), 32'd1);
        drain();
        check("hold_frames", 32'(frames_seen - f0), 32'd1);

        // Overflow: ten writes into an eight-deep FIFO.
        f0 = frames_seen;
        for (int i = 0; i < 10; i++) cycle(TXDATA, 32'(8'h40 + i), 1'b1, 1'b0);
        cycle(STATUS, 32'h0, 1'b0, 1'b0);
        #1;
        check("ovf_full_and_flag", q_dmem & 32'h5, 32'h5);
        cycle(STATUS, 32'h4, 1'b1, 1'b0);
        cycle(STATUS, 32'h0, 1'b0, 1'b0);
        #1;
        check("ovf_cleared", 32'(q_dmem[2]), 32'd0);
        drain();
        check("ovf_frames", 32'(frames_seen - f0), 32'd9);

        // Back-to-back frames.
        cycle(TXDATA, 32'h01, 1'b1, 1'b0);
        cycle(TXDATA, 32'h02, 1'b1, 1'b0);
        drain();
        check("b2b_gap", 32'(last_start - prev_start), 32'(FRAME));

        // Reset during DATA bit 3 of 0x00 with two bytes queued.
        cycle(TXDATA, 32'h00, 1'b1, 1'b0);
        cycle(TXDATA, 32'h11, 1'b1, 1'b0);
        cycle(TXDATA, 32'h22, 1'b1, 1'b0);
        idle(16);
        @(posedge clock);
        #1;
        check("pre_reset_tx_low", 32'(tx), 32'd0);
        reset        = 1'b0;
        address_dmem = '0;
        wren         = 1'b0;
        m_fifo.delete();
        exp_tx.delete();
        rd_q.delete();
        m_rem = 0;
        m_ovf = 0;
        #1;
        check("reset_async_tx", 32'(tx), 32'd1);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        cycle(STATUS, 32'h0, 1'b0, 1'b0);
        #1;
        check("post_reset_status", q_dmem, 32'h0000_0002);
        idle(2);

        // Randomized mix over every target.
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 9);
            d = $urandom();
            case (r)
                0, 1:    cycle(32'($urandom_range(0, 31)), d, 1'b1, 1'($urandom_range(0, 3) == 0));
                2, 3:    cycle(32'($urandom_range(0, 31)), d, 1'b0, 1'b0);
                4:       cycle(TXDATA, d, 1'b1, 1'($urandom_range(0, 2) == 0));
                5:       cycle(STATUS, d, 1'b0, 1'b0);
                6:       cycle(STATUS, d, 1'b1, 1'($urandom_range(0, 1)));
                7: begin
                    case ($urandom_range(0, 2))
                        0:       a = 32'h0000_1000 + 32'($urandom_range(0, 4095));
                        1:       a = 32'hFFFF_F008;
                        default: a = 32'h8000_0000 | 32'($urandom_range(0, 255));
                    endcase
                    cycle(a, d, 1'($urandom_range(0, 1)), 1'b0);
                end
                8:       cycle(TXDATA, d, 1'b0, 1'b0);
                default: idle(1);
            endcase
        end
        drain();
        check("all_frames_seen", 32'(exp_tx.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
